// File: rtl/mul_fu_ctrl.sv
// Sequencer between the multiply reservation station and a multi-cycle unsigned 32x32 multiplier.
// Optional MUL_CDB_FWD_EN lets a result go straight to the CDB in its mult_done cycle.
module mul_fu_ctrl #(
    parameter int ROB_IDX_W = 5,
    parameter int RVFI_W    = 64   // rd_wdata occupies bits [31:0] of the trace packet
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [1:0]           iss_mulop,
    input  logic [31:0]          iss_rs1_v,
    input  logic [31:0]          iss_rs2_v,
    input  logic [ROB_IDX_W-1:0] iss_rob_idx,
    input  logic [4:0]           iss_rd,
    input  logic [RVFI_W-1:0]    iss_rvfi,
    output logic                 mult_start,
    output logic [31:0]          mult_a,
    output logic [31:0]          mult_b,
    output logic                 mult_abort,
    input  logic                 mult_done,
    input  logic [63:0]          mult_p,
    output logic                 cdb_valid,
    input  logic                 cdb_grant,
    output logic [ROB_IDX_W-1:0] cdb_rob_idx,
    output logic [4:0]           cdb_rd,
    output logic [31:0]          cdb_data,
    output logic [RVFI_W-1:0]    cdb_rvfi,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_e                state_q, state_d;
    logic [1:0]            op_q;
    logic [ROB_IDX_W-1:0]  rob_q;
    logic [4:0]            rd_q;
    logic [RVFI_W-1:32]    rvfi_q;
    logic [31:0]           a_q, b_q, res_q;
    logic                  neg_q, start_q, abort_q;

    logic                  accept;
    logic                  rs1_signed, rs2_signed;
    logic [31:0]           a_d, b_d;
    logic                  neg_d;
    logic [63:0]           prod_fix;
    logic [31:0]           prod_sel;
    logic [31:0]           unused_rvfi_lo;

    assign unused_rvfi_lo = iss_rvfi[31:0];

    // Operand magnitudes and result sign from the M-extension signedness of each op.
    assign rs1_signed = (iss_mulop == OP_MULH) || (iss_mulop == OP_MULHSU);
    assign rs2_signed = (iss_mulop == OP_MULH);
    assign a_d   = (rs1_signed && iss_rs1_v[31]) ? (~iss_rs1_v + 32'd1) : iss_rs1_v;
    assign b_d   = (rs2_signed && iss_rs2_v[31]) ? (~iss_rs2_v + 32'd1) : iss_rs2_v;
    assign neg_d = (rs1_signed && iss_rs1_v[31]) ^ (rs2_signed && iss_rs2_v[31]);

    assign prod_fix = neg_q ? (~mult_p + 64'd1) : mult_p;
    assign prod_sel = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];

    assign accept = iss_valid && iss_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (mult_done) begin
`ifdef MUL_CDB_FWD_EN
                state_d = cdb_grant ? IDLE : DONE;
`else
                state_d = DONE;
`endif
            end
            DONE: if (cdb_grant && cdb_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        iss_ready = (state_q == IDLE) && !flush;
        busy      = (state_q != IDLE);
        cdb_valid = (state_q == DONE) && !flush;
        cdb_data  = res_q;
`ifdef MUL_CDB_FWD_EN
        if (state_q == BUSY) begin
            cdb_valid = mult_done && !flush;
            cdb_data  = prod_sel;
        end
`endif
    end

    assign mult_start  = start_q;
    assign mult_abort  = abort_q;
    assign mult_a      = a_q;
    assign mult_b      = b_q;
    assign cdb_rob_idx = rob_q;
    assign cdb_rd      = rd_q;
    assign cdb_rvfi    = {rvfi_q, cdb_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            rob_q   <= '0;
            rd_q    <= '0;
            rvfi_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            start_q <= accept;
            abort_q <= flush && (state_q == BUSY);
            if (accept) begin
                op_q   <= iss_mulop;
                rob_q  <= iss_rob_idx;
                rd_q   <= iss_rd;
                rvfi_q <= iss_rvfi[RVFI_W-1:32];
                a_q    <= a_d;
                b_q    <= b_d;
                neg_q  <= neg_d;
            end
            if ((state_q == BUSY) && mult_done && !flush) res_q <= prod_sel;
        end
    end

endmodule

// File: tb/tb_mul_fu_ctrl.sv
// Directed bench for mul_fu_ctrl; the multiplier is stood in for by hand-timed done pulses.
module tb_mul_fu_ctrl;

`ifdef MUL_CDB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, iss_valid, iss_ready;
    logic [1:0]  iss_mulop;
    logic [31:0] iss_rs1_v, iss_rs2_v;
    logic [4:0]  iss_rob_idx, iss_rd;
    logic [63:0] iss_rvfi;
    logic        mult_start, mult_abort, mult_done;
    logic [31:0] mult_a, mult_b;
    logic [63:0] mult_p;
    logic        cdb_valid, cdb_grant;
    logic [4:0]  cdb_rob_idx, cdb_rd;
    logic [31:0] cdb_data;
    logic [63:0] cdb_rvfi;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_fu_ctrl #(.ROB_IDX_W(5), .RVFI_W(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_mulop(iss_mulop),
        .iss_rs1_v(iss_rs1_v), .iss_rs2_v(iss_rs2_v), .iss_rob_idx(iss_rob_idx),
        .iss_rd(iss_rd), .iss_rvfi(iss_rvfi),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_abort(mult_abort), .mult_done(mult_done), .mult_p(mult_p),
        .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_rob_idx(cdb_rob_idx),
        .cdb_rd(cdb_rd), .cdb_data(cdb_data), .cdb_rvfi(cdb_rvfi), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single cycle; returns in the first BUSY cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rob, input logic [4:0] rd);
        iss_valid = 1'b1; iss_mulop = op; iss_rs1_v = rs1; iss_rs2_v = rs2;
        iss_rob_idx = rob; iss_rd = rd; iss_rvfi = {24'hA5A5A5, 3'b000, rd, 32'h0};
        #1 chk("iss_ready_idle", iss_ready, 1);
        tick;
        iss_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] ea, input logic [31:0] eb, input logic [63:0] p,
                          input logic [31:0] ed, input logic [4:0] rob, input logic [4:0] rd,
                          input int hold);
        issue(op, rs1, rs2, rob, rd);
        #1;
        chk("mult_start_T1", mult_start, 1);
        chk("mult_a", mult_a, ea);
        chk("mult_b", mult_b, eb);
        chk("busy_T1", busy, 1);
        tick;
        chk("mult_start_T2", mult_start, 0);
        chk("mult_a_stable", mult_a, ea);
        tick;
        mult_done = 1'b1; mult_p = p;
        #1 chk("cdb_valid_D", cdb_valid, FWD);
        if (FWD) chk("cdb_data_D", cdb_data, ed);
        tick;
        mult_done = 1'b0; mult_p = '0;
        for (int i = 0; i < hold; i++) begin
            iss_valid = 1'b1;
            #1;
            chk("hold_valid", cdb_valid, 1);
            chk("hold_data", cdb_data, ed);
            chk("hold_rob", cdb_rob_idx, rob);
            chk("hold_ready", iss_ready, 0);
            tick;
        end
        iss_valid = 1'b0; cdb_grant = 1'b1;
        #1;
        chk("cdb_valid", cdb_valid, 1);
        chk("cdb_data", cdb_data, ed);
        chk("cdb_rob_idx", cdb_rob_idx, rob);
        chk("cdb_rd", cdb_rd, rd);
        chk("cdb_rvfi", cdb_rvfi, {24'hA5A5A5, 3'b000, rd, ed});
        tick;
        cdb_grant = 1'b0;
        #1;
        chk("ready_after_grant", iss_ready, 1);
        chk("busy_after_grant", busy, 0);
        chk("valid_after_grant", cdb_valid, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_mulop = '0; iss_rs1_v = '0;
        iss_rs2_v = '0; iss_rob_idx = '0; iss_rd = '0; iss_rvfi = '0;
        mult_done = 1'b0; mult_p = '0; cdb_grant = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_start", mult_start, 0);
        chk("rst_abort", mult_abort, 0);
        chk("rst_cdb_valid", cdb_valid, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_cdb_data", cdb_data, 0);
        rst = 1'b0;
        tick;
        chk("rst_ready", iss_ready, 1);

        run_op(2'b00, 32'd7,        32'hFFFFFFFD, 32'd7,        32'hFFFFFFFD,
               64'h6_FFFFFFEB,          32'hFFFFFFEB, 5'd3,  5'd10, 0);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd1,
               64'h1,                   32'h00000000, 5'd4,  5'd11, 0);
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               64'hFFFFFFFE_00000001,   32'hFFFFFFFE, 5'd5,  5'd12, 0);
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,
               64'h00000000_FFFFFFFF,   32'hFFFFFFFF, 5'd6,  5'd13, 0);
        run_op(2'b01, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
               64'h40000000_00000000,   32'h40000000, 5'd7,  5'd14, 5);
        run_op(2'b01, 32'hFFFFFFFE, 32'd3,        32'd2,        32'd3,
               64'h6,                   32'hFFFFFFFF, 5'd31, 5'd1,  0);

        // Flush mid-BUSY, then a stray done from the aborted multiplier.
        issue(2'b00, 32'd5, 32'd6, 5'd8, 5'd2);
        flush = 1'b1;
        #1 chk("flush_ready", iss_ready, 0);
        tick;
        flush = 1'b0;
        #1;
        chk("flush_abort", mult_abort, 1);
        chk("flush_busy", busy, 0);
        chk("flush_ready_next", iss_ready, 1);
        mult_done = 1'b1; mult_p = 64'd30;
        #1 chk("flush_done_valid", cdb_valid, 0);
        tick;
        mult_done = 1'b0;
        #1;
        chk("abort_one_pulse", mult_abort, 0);
        chk("flush_valid_after", cdb_valid, 0);
        chk("flush_idle", busy, 0);

        // Flush in DONE with a simultaneous grant: nothing retires.
        issue(2'b00, 32'd2, 32'd3, 5'd9, 5'd3);
        tick;
        mult_done = 1'b1; mult_p = 64'd6;
        tick;
        mult_done = 1'b0;
        #1 chk("done_valid", cdb_valid, 1);
        flush = 1'b1; cdb_grant = 1'b1;
        #1 chk("done_flush_valid", cdb_valid, 0);
        tick;
        flush = 1'b0; cdb_grant = 1'b0;
        #1;
        chk("done_flush_idle", busy, 0);
        chk("done_flush_noabort", mult_abort, 0);
        chk("done_flush_valid_next", cdb_valid, 0);

        // Done while IDLE is ignored.
        mult_done = 1'b1; mult_p = 64'h1234;
        #1 chk("idle_done_valid", cdb_valid, 0);
        tick;
        mult_done = 1'b0;
        #1;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_valid_next", cdb_valid, 0);

`ifdef MUL_CDB_FWD_EN
        // Forwarded result granted in its done cycle skips DONE.
        issue(2'b00, 32'd9, 32'd9, 5'd12, 5'd4);
        tick;
        mult_done = 1'b1; mult_p = 64'd81; cdb_grant = 1'b1;
        #1;
        chk("fwd_valid", cdb_valid, 1);
        chk("fwd_data", cdb_data, 32'd81);
        chk("fwd_rob", cdb_rob_idx, 5'd12);
        tick;
        mult_done = 1'b0; cdb_grant = 1'b0;
        #1;
        chk("fwd_ready", iss_ready, 1);
        chk("fwd_busy", busy, 0);
        chk("fwd_valid_next", cdb_valid, 0);
`endif

        // Async reset during the start cycle.
        issue(2'b01, 32'hFFFFFFF0, 32'd4, 5'd10, 5'd5);
        #1 chk("pre_rst_start", mult_start, 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_start", mult_start, 0);
        chk("arst_valid", cdb_valid, 0);
        chk("arst_mult_a", mult_a, 0);
        tick;
        rst = 1'b0;
        tick;
        chk("arst_ready", iss_ready, 1);
        chk("arst_abort", mult_abort, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
